i2c_slave_regfile: RTL and testbench

Synthesizable I2C target (slave) that responds to the i2c_master DUT on the shared open-drain bus, in the style of a small EEPROM-like register file. It oversamples SCL/SDA on the Wishbone clock, decodes START/STOP, matches a 7-bit address, and ACKs. It stores write bytes at an auto-incrementing pointer and returns bytes on reads. The block sits on the bench/system bus opposite the master and also exposes write-event strobes for scoreboarding.

---
 rtl/i2c_slave_regfile_if.sv | 23 ++
 rtl/i2c_slave_regfile.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regfile_if.sv
// Bus-side signal bundle for the I2C register-file target: pin levels in, open-drain enables and write strobes out.
interface i2c_slave_regfile_if #(
    parameter int REG_AW = 3
);
    logic              scl_i;
    logic              sda_i;
    logic              sda_oe_o;
    logic              scl_oe_o;
    logic              wr_stb_o;
    logic [REG_AW-1:0] wr_addr_o;
    logic [7:0]        wr_data_o;
    logic              busy_o;

    modport slave (
        input  scl_i, sda_i,
        output sda_oe_o, scl_oe_o, wr_stb_o, wr_addr_o, wr_data_o, busy_o
    );

    modport master (
        output scl_i, sda_i,
        input  sda_oe_o, scl_oe_o, wr_stb_o, wr_addr_o, wr_data_o, busy_o
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// EEPROM-style I2C target: oversampled SCL/SDA, 7-bit address match, auto-incrementing byte pointer.
// Optional clock stretching after each ACK/NACK slot is enabled by defining I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h51,
    parameter int         REG_AW         = 3,
    parameter logic [7:0] RESET_VAL      = 8'h00,
    parameter int         STRETCH_CYCLES = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    i2c_slave_regfile_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK, WAIT_STOP
    } state_t;

    state_t            state, state_n;
    logic [1:0]        scl_sync, sda_sync;
    logic              scl_d, sda_d;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shift, shift_n;
    logic              ack_ph, ack_ph_n;
    logic              rw, rw_n;
    logic              nack, nack_n;
    logic              sda_oe, sda_oe_n;
    logic              busy, busy_n;
    logic [REG_AW-1:0] ptr, ptr_n;
    logic              wr_stb, wr_stb_n;
    logic [REG_AW-1:0] wr_addr, wr_addr_n;
    logic [7:0]        wr_data, wr_data_n;
    logic              reg_we;
    logic [7:0]        regs [2**REG_AW];

    wire scl_s    = scl_sync[1];
    wire sda_s    = sda_sync[1];
    wire scl_rise = scl_s & ~scl_d;
    wire scl_fall = ~scl_s & scl_d;
    wire start    = scl_s & scl_d & sda_d & ~sda_s;
    wire stop     = scl_s & scl_d & ~sda_d & sda_s;
    wire [7:0] rx_byte = {shift[6:0], sda_s};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            ack_ph   <= 1'b0;
            rw       <= 1'b0;
            nack     <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= RESET_VAL;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            ack_ph   <= ack_ph_n;
            rw       <= rw_n;
            nack     <= nack_n;
            sda_oe   <= sda_oe_n;
            busy     <= busy_n;
            ptr      <= ptr_n;
            wr_stb   <= wr_stb_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            if (reg_we) regs[ptr] <= rx_byte;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ack_ph_n  = ack_ph;
        rw_n      = rw;
        nack_n    = nack;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        ptr_n     = ptr;
        wr_stb_n  = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        reg_we    = 1'b0;
        // Bus conditions take priority over any SCL edge seen in the same cycle.
        if (stop) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            busy_n   = 1'b0;
        end else if (start) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            ack_ph_n  = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: if (scl_rise) begin
                    shift_n   = rx_byte;
                    bit_cnt_n = bit_cnt + 4'd1;
                    ack_ph_n  = 1'b0;
                    if (bit_cnt == 4'd7) begin
                        if (state == ADDR) begin
                            if (shift[6:0] == SLAVE_ADDR) begin
                                state_n = ADDR_ACK;
                                rw_n    = sda_s;
                                busy_n  = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                                busy_n  = 1'b0;
                            end
                        end else if (state == PTR) begin
                            ptr_n   = rx_byte[REG_AW-1:0];
                            state_n = PTR_ACK;
                        end else begin
                            reg_we    = 1'b1;
                            wr_stb_n  = 1'b1;
                            wr_addr_n = ptr;
                            wr_data_n = rx_byte;
                            ptr_n     = ptr + 1'b1;
                            state_n   = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    // First fall starts the ACK slot, second fall ends it.
                    if (!ack_ph) begin
                        sda_oe_n = 1'b1;
                        ack_ph_n = 1'b1;
                    end else begin
                        ack_ph_n  = 1'b0;
                        bit_cnt_n = '0;
                        if (state == ADDR_ACK && rw) begin
                            shift_n  = regs[ptr];
                            sda_oe_n = ~regs[ptr][7];
                            state_n  = RDATA;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = (state == ADDR_ACK) ? PTR : WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_n = 1'b0;
                            ptr_n    = ptr + 1'b1;
                            ack_ph_n = 1'b0;
                            state_n  = MACK;
                        end else begin
                            sda_oe_n = ~shift[3'd7 - bit_cnt[2:0]];
                        end
                    end
                end
                MACK: begin
                    if (scl_rise && !ack_ph) begin
                        nack_n   = sda_s;
                        ack_ph_n = 1'b1;
                    end else if (scl_fall && ack_ph) begin
                        ack_ph_n  = 1'b0;
                        bit_cnt_n = '0;
                        if (nack) begin
                            state_n = WAIT_STOP;
                        end else begin
                            shift_n  = regs[ptr];
                            sda_oe_n = ~regs[ptr][7];
                            state_n  = RDATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe_o  = sda_oe;
    assign bus.wr_stb_o  = wr_stb;
    assign bus.wr_addr_o = wr_addr;
    assign bus.wr_data_o = wr_data;
    assign bus.busy_o    = busy;

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    logic          scl_oe;
    logic [SW-1:0] str_cnt;
    wire ack_end = scl_fall & ack_ph & ~start & ~stop &
                   (state == ADDR_ACK || state == PTR_ACK || state == WDATA_ACK || state == MACK);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || start || stop) begin
            scl_oe  <= 1'b0;
            str_cnt <= '0;
        end else if (ack_end) begin
            scl_oe  <= 1'b1;
            str_cnt <= SW'(STRETCH_CYCLES - 1);
        end else if (scl_oe) begin
            if (str_cnt == '0) scl_oe <= 1'b0;
            else               str_cnt <= str_cnt - 1'b1;
        end
    end
    assign bus.scl_oe_o = scl_oe;
`else
    assign bus.scl_oe_o = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged I2C master on a wired-AND bus, assertion-checked against hand-computed values.
module tb_i2c_slave_regfile;
    localparam int Q = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic last_oe;
    logic ack;
    logic [7:0] d;

    int         ev_cnt = 0;
    logic [2:0] ev_addr [64];
    logic [7:0] ev_data [64];
    int         oe_cycles = 0;
    int         busy_cycles = 0;
    int         str_cycles = 0;
    int         str_rises = 0;
    logic       str_prev = 1'b0;

    i2c_slave_regfile_if #(.REG_AW(3)) bus ();

    assign bus.scl_i = scl_m & ~bus.scl_oe_o;
    assign bus.sda_i = sda_m & ~bus.sda_oe_o;

    i2c_slave_regfile dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_stb_o && ev_cnt < 64) begin
            ev_addr[ev_cnt] = bus.wr_addr_o;
            ev_data[ev_cnt] = bus.wr_data_o;
            ev_cnt++;
        end
        if (bus.sda_oe_o) oe_cycles++;
        if (bus.busy_o) busy_cycles++;
        if (bus.scl_oe_o) str_cycles++;
        if (bus.scl_oe_o && !str_prev) str_rises++;
        str_prev = bus.scl_oe_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n = Q);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_up();
        int n = 0;
        scl_m = 1'b1;
        while (bus.scl_i !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("scl_release_timeout", 32'd0, 32'd1);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_up();     wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_up();     wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wq();
        scl_up(); wq(Q / 2);
        last_oe = bus.sda_oe_o;
        wq(Q / 2);
        scl_m = 1'b0; wq();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wq();
        scl_up(); wq(Q / 2);
        b = bus.sda_i;
        wq(Q / 2);
        scl_m = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] v, output logic a);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(a);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic m_ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(m_ack);
        chk("mack_sda_released", 32'(last_oe), 32'd0);
    endtask

    initial begin
        int ev0, oe0, busy0;

        // Reset state
        wq(3);
        chk("rst_sda_oe", 32'(bus.sda_oe_o), 32'd0);
        chk("rst_scl_oe", 32'(bus.scl_oe_o), 32'd0);
        chk("rst_wr_stb", 32'(bus.wr_stb_o), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr_o), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        rst = 1'b0;
        wq();

        // Write 0x5A, 0xC3 starting at register 2
        i2c_start();
        write_byte(8'hA2, ack); chk("wr_addr_ack", 32'(ack), 32'd0);
        chk("wr_busy_high", 32'(bus.busy_o), 32'd1);
        write_byte(8'h02, ack); chk("wr_ptr_ack", 32'(ack), 32'd0);
        write_byte(8'h5A, ack); chk("wr_d0_ack", 32'(ack), 32'd0);
        write_byte(8'hC3, ack); chk("wr_d1_ack", 32'(ack), 32'd0);
        i2c_stop();
        wq(5);
        chk("wr_busy_low", 32'(bus.busy_o), 32'd0);
        chk("wr_ev_count", 32'(ev_cnt), 32'd2);
        chk("wr_ev0_addr", 32'(ev_addr[0]), 32'd2);
        chk("wr_ev0_data", 32'(ev_data[0]), 32'h5A);
        chk("wr_ev1_addr", 32'(ev_addr[1]), 32'd3);
        chk("wr_ev1_data", 32'(ev_data[1]), 32'hC3);

        // Read back through a repeated START
        i2c_start();
        write_byte(8'hA2, ack); chk("rd_waddr_ack", 32'(ack), 32'd0);
        write_byte(8'h02, ack); chk("rd_ptr_ack", 32'(ack), 32'd0);
        i2c_start();
        write_byte(8'hA3, ack); chk("rd_raddr_ack", 32'(ack), 32'd0);
        read_byte(d, 1'b0); chk("rd_byte0", 32'(d), 32'h5A);
        read_byte(d, 1'b1); chk("rd_byte1", 32'(d), 32'hC3);
        i2c_stop();
        // Pointer now 4: a fresh read returns untouched register 4
        i2c_start();
        write_byte(8'hA3, ack); chk("rd_ptr4_ack", 32'(ack), 32'd0);
        read_byte(d, 1'b1); chk("rd_ptr4_byte", 32'(d), 32'h00);
        i2c_stop();
        chk("rd_no_writes", 32'(ev_cnt), 32'd2);

        // Address mismatch: bus never driven, no busy, no writes
        ev0 = ev_cnt; oe0 = oe_cycles; busy0 = busy_cycles;
        i2c_start();
        write_byte(8'hA0, ack); chk("mm_addr_nack", 32'(ack), 32'd1);
        write_byte(8'h12, ack); chk("mm_data_nack", 32'(ack), 32'd1);
        i2c_stop();
        chk("mm_sda_never", 32'(oe_cycles - oe0), 32'd0);
        chk("mm_busy_never", 32'(busy_cycles - busy0), 32'd0);
        chk("mm_no_writes", 32'(ev_cnt - ev0), 32'd0);

        // Pointer wrap 7 -> 0 -> 1
        i2c_start();
        write_byte(8'hA2, ack);
        write_byte(8'h07, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack);
        write_byte(8'h33, ack); chk("wrap_last_ack", 32'(ack), 32'd0);
        i2c_stop();
        chk("wrap_ev_count", 32'(ev_cnt), 32'd5);
        chk("wrap_ev2", {ev_addr[2], ev_data[2]}, {3'd7, 8'h11});
        chk("wrap_ev3", {ev_addr[3], ev_data[3]}, {3'd0, 8'h22});
        chk("wrap_ev4", {ev_addr[4], ev_data[4]}, {3'd1, 8'h33});
        i2c_start();
        write_byte(8'hA2, ack);
        write_byte(8'h07, ack);
        i2c_start();
        write_byte(8'hA3, ack);
        read_byte(d, 1'b0); chk("wrap_rd7", 32'(d), 32'h11);
        read_byte(d, 1'b0); chk("wrap_rd0", 32'(d), 32'h22);
        read_byte(d, 1'b1); chk("wrap_rd1", 32'(d), 32'h33);
        i2c_stop();

        // Reset during a read while the target holds SDA low (reg0 = 0x22, bit3 = 0)
        i2c_start();
        write_byte(8'hA2, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'hA3, ack);
        for (int i = 0; i < 4; i++) read_bit(d[0]);
        chk("abort_sda_driven", 32'(bus.sda_oe_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_sda_released", 32'(bus.sda_oe_o), 32'd0);
        rst = 1'b0;
        i2c_stop();
        i2c_start();
        write_byte(8'hA2, ack); chk("abort_next_ack", 32'(ack), 32'd0);
        write_byte(8'h02, ack);
        i2c_start();
        write_byte(8'hA3, ack);
        read_byte(d, 1'b0); chk("abort_reg2_reset", 32'(d), 32'h00);
        read_byte(d, 1'b1); chk("abort_reg3_reset", 32'(d), 32'h00);
        i2c_stop();

        // STOP after 4 data bits discards the partial byte
        i2c_start();
        write_byte(8'hA2, ack);
        write_byte(8'h04, ack);
        write_byte(8'h77, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        chk("partial_ev_count", 32'(ev_cnt), 32'd6);
        chk("partial_ev5", {ev_addr[5], ev_data[5]}, {3'd4, 8'h77});
        i2c_start();
        write_byte(8'hA3, ack);
        read_byte(d, 1'b1); chk("partial_reg5", 32'(d), 32'h00);
        i2c_stop();
        wq(5);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
        chk("stretch_present", 32'(str_rises > 0), 32'd1);
        chk("stretch_len", 32'(str_cycles), 32'(16 * str_rises));
`else
        chk("stretch_absent", 32'(str_cycles), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
